// File: rtl/serial_pkg.sv
// Shared constants and drain FSM state encoding for the serial TX queue.
package serial_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } drain_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with AW+1 bit pointers; the extra MSB tells full from empty.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_dat,
    input  logic          rd_en,
    output logic [7:0]    rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push;
    logic        pop;

    // Full and empty come from registered pointers only, so a push on a full
    // FIFO is dropped even when a pop happens in the same cycle.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        count    = wr_ptr_q - rd_ptr_q;
        rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/serial_tx_queue.sv
// Transmit queue draining bytes into serial_port one per tx_rdy window.
// Optional CR-before-LF expansion is enabled by defining SERIAL_TXQ_CRLF_EN.
module serial_tx_queue
    import serial_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_dat,
    input  logic          in_stb,
    output logic          in_full,
    output logic [AW:0]   in_count,
    output logic          overflow,
    output logic [7:0]    tx_dat,
    output logic          tx_stb,
    input  logic          tx_rdy
);

    drain_state_e state_q, state_d;
    logic [7:0]   tx_dat_q, tx_dat_d;
    logic         tx_stb_q, tx_stb_d;
    logic         overflow_q, overflow_d;
    logic         fifo_empty;
    logic [7:0]   fifo_head;
    logic         pop;
`ifdef SERIAL_TXQ_CRLF_EN
    logic         lf_pending_q, lf_pending_d;
`endif

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_stb),
        .wr_dat (in_dat),
        .rd_en  (pop),
        .rd_dat (fifo_head),
        .full   (in_full),
        .empty  (fifo_empty),
        .count  (in_count)
    );

    // HOLD keeps the FSM from sampling tx_rdy while the strobe is still high,
    // since serial_port only drops tx_rdy the cycle after it sees tx_stb.
    always_comb begin
        state_d    = state_q;
        tx_dat_d   = tx_dat_q;
        tx_stb_d   = 1'b0;
        pop        = 1'b0;
        overflow_d = overflow_q | (in_stb & in_full);
`ifdef SERIAL_TXQ_CRLF_EN
        lf_pending_d = lf_pending_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && tx_rdy) begin
                    tx_stb_d = 1'b1;
                    state_d  = HOLD;
`ifdef SERIAL_TXQ_CRLF_EN
                    if (fifo_head == ASCII_LF && !lf_pending_q) begin
                        tx_dat_d     = ASCII_CR;
                        lf_pending_d = 1'b1;
                    end else begin
                        tx_dat_d     = fifo_head;
                        pop          = 1'b1;
                        lf_pending_d = 1'b0;
                    end
`else
                    tx_dat_d = fifo_head;
                    pop      = 1'b1;
`endif
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_dat_q   <= 8'h00;
            tx_stb_q   <= 1'b0;
            overflow_q <= 1'b0;
`ifdef SERIAL_TXQ_CRLF_EN
            lf_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_dat_q   <= tx_dat_d;
            tx_stb_q   <= tx_stb_d;
            overflow_q <= overflow_d;
`ifdef SERIAL_TXQ_CRLF_EN
            lf_pending_q <= lf_pending_d;
`endif
        end
    end

    assign tx_dat   = tx_dat_q;
    assign tx_stb   = tx_stb_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx_queue.sv
// Self-checking bench for serial_tx_queue: directed scenarios plus a random phase,
// checked against a queue-based reference model and a serial_port tx_rdy model.
module tb_serial_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_dat;
    logic          in_stb;
    logic          in_full;
    logic [AW:0]   in_count;
    logic          overflow;
    logic [7:0]    tx_dat;
    logic          tx_stb;
    logic          tx_rdy;

    int            checks_total  = 0;
    int            checks_passed = 0;
    logic [7:0]    model_q[$];
    logic [7:0]    sent_log[$];
    bit            model_ov = 1'b0;
    bit            model_lf = 1'b0;
    bit            prev_stb = 1'b0;
    int            rdy_mode = 0;
    int            busy     = 0;
    int            baud     = 10;
    int            mark;

    always #5 clk = ~clk;

    serial_tx_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_stb   (in_stb),
        .in_full  (in_full),
        .in_count (in_count),
        .overflow (overflow),
        .tx_dat   (tx_dat),
        .tx_stb   (tx_stb),
        .tx_rdy   (tx_rdy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Advance one clock, update the reference model with what the edge did,
    // check outputs, then drive tx_rdy for the new cycle.
    task automatic tick();
        logic       p_rst;
        logic       p_stb;
        logic [7:0] p_dat;
        logic [7:0] exp_byte;
        p_rst = rst;
        p_stb = in_stb;
        p_dat = in_dat;
        @(posedge clk);
        #1;
        if (p_rst) begin
            model_q.delete();
            model_ov = 1'b0;
            model_lf = 1'b0;
            busy     = 0;
        end else if (p_stb) begin
            if (model_q.size() == DEPTH) model_ov = 1'b1;
            else model_q.push_back(p_dat);
        end
        if (tx_stb === 1'b1) begin
            checkOutput("stb_adjacent", {31'd0, prev_stb}, 0);
            checkOutput("stb_without_rdy", {31'd0, tx_rdy}, 1);
            sent_log.push_back(tx_dat);
            if (model_q.size() == 0) begin
                checkOutput("stb_on_empty", {31'd0, tx_stb}, 0);
            end else begin
`ifdef SERIAL_TXQ_CRLF_EN
                if (model_q[0] == 8'h0A && !model_lf) begin
                    exp_byte = 8'h0D;
                    model_lf = 1'b1;
                end else begin
                    exp_byte = model_q.pop_front();
                    model_lf = 1'b0;
                end
`else
                exp_byte = model_q.pop_front();
`endif
                checkOutput("tx_dat", {24'd0, tx_dat}, {24'd0, exp_byte});
            end
        end
        checkOutput("in_count", {27'd0, in_count}, model_q.size());
        checkOutput("in_full", {31'd0, in_full}, (model_q.size() == DEPTH) ? 1 : 0);
        checkOutput("overflow", {31'd0, overflow}, {31'd0, model_ov});
        prev_stb = (tx_stb === 1'b1);
        case (rdy_mode)
            0: tx_rdy = 1'b0;
            1: tx_rdy = 1'b1;
            default: begin
                tx_rdy = (busy == 0);
                if (busy > 0) busy--;
            end
        endcase
        if (tx_stb === 1'b1) busy = baud;
    endtask

    task automatic applyStimulus(input logic stb, input logic [7:0] dat);
        in_stb = stb;
        in_dat = dat;
        tick();
        in_stb = 1'b0;
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        while (model_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", model_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        rst    = 1'b1;
        in_stb = 1'b0;
        in_dat = 8'h00;
        tx_rdy = 1'b0;
        repeat (3) tick();
        checkOutput("reset_tx_dat", {24'd0, tx_dat}, 0);
        checkOutput("reset_tx_stb", {31'd0, tx_stb}, 0);
        checkOutput("reset_in_count", {27'd0, in_count}, 0);
        checkOutput("reset_in_full", {31'd0, in_full}, 0);
        checkOutput("reset_overflow", {31'd0, overflow}, 0);
        rst = 1'b0;

        $display("[TB] single byte latency");
        rdy_mode = 1;
        repeat (2) tick();
        applyStimulus(1'b1, 8'h41);
        checkOutput("lat_n1_stb", {31'd0, tx_stb}, 0);
        tick();
        checkOutput("lat_n2_stb", {31'd0, tx_stb}, 1);
        checkOutput("lat_n2_dat", {24'd0, tx_dat}, 8'h41);
        tick();
        checkOutput("lat_n3_stb", {31'd0, tx_stb}, 0);
        checkOutput("lat_n3_count", {27'd0, in_count}, 0);
        repeat (3) tick();
        checkOutput("tx_dat_hold", {24'd0, tx_dat}, 8'h41);

        $display("[TB] backpressure at baud 10");
        rdy_mode = 2;
        baud     = 10;
        busy     = 0;
        mark     = sent_log.size();
        applyStimulus(1'b1, 8'h31);
        applyStimulus(1'b1, 8'h32);
        applyStimulus(1'b1, 8'h33);
        drainAll(200);
        checkOutput("bp_pulses", sent_log.size() - mark, 3);
        checkOutput("bp_order2", {24'd0, sent_log[mark+2]}, 8'h33);

        $display("[TB] wrap-around stream");
        rdy_mode = 1;
        tick();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, i[7:0]);
            repeat ($urandom_range(1, 2)) tick();
        end
        drainAll(200);
        checkOutput("wrap_overflow", {31'd0, overflow}, 0);

        $display("[TB] full and overflow");
        rdy_mode = 0;
        tick();
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(1'b1, i[7:0]);
        end
        checkOutput("full_in_full", {31'd0, in_full}, 1);
        checkOutput("full_in_count", {27'd0, in_count}, 16);
        checkOutput("full_overflow", {31'd0, overflow}, 1);
        mark     = sent_log.size();
        rdy_mode = 2;
        busy     = 0;
        baud     = 3;
        drainAll(400);
        checkOutput("full_sent", sent_log.size() - mark, 16);
        checkOutput("full_last", {24'd0, sent_log[sent_log.size()-1]}, 8'h0F);

        $display("[TB] reset mid-stream");
        rdy_mode = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        end
        checkOutput("pre_reset_count", {27'd0, in_count}, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_in_count", {27'd0, in_count}, 0);
        checkOutput("rst_tx_stb", {31'd0, tx_stb}, 0);
        checkOutput("rst_overflow", {31'd0, overflow}, 0);
        mark     = sent_log.size();
        rdy_mode = 1;
        repeat (20) tick();
        checkOutput("post_reset_quiet", sent_log.size() - mark, 0);

        $display("[TB] CR/LF handling");
        rdy_mode = 2;
        busy     = 0;
        baud     = 4;
        mark     = sent_log.size();
        applyStimulus(1'b1, 8'h48);
        applyStimulus(1'b1, 8'h0A);
        drainAll(200);
        checkOutput("crlf_seq0", {24'd0, sent_log[mark]}, 8'h48);
`ifdef SERIAL_TXQ_CRLF_EN
        checkOutput("crlf_pulses", sent_log.size() - mark, 3);
        checkOutput("crlf_seq1", {24'd0, sent_log[mark+1]}, 8'h0D);
        checkOutput("crlf_seq2", {24'd0, sent_log[mark+2]}, 8'h0A);
`else
        checkOutput("crlf_pulses", sent_log.size() - mark, 2);
        checkOutput("crlf_seq1", {24'd0, sent_log[mark+1]}, 8'h0A);
`endif

        $display("[TB] random traffic");
        for (int r = 0; r < 4; r++) begin
            baud = $urandom_range(1, 6);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b1, ($urandom_range(0, 3) == 0) ? 8'h0A
                                        : 8'($urandom_range(0, 255)));
                end else begin
                    tick();
                end
            end
            drainAll(1000);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
